serial_adder: RTL and testbench

//  Bit-serial N-bit adder, LSB first: the addition counterpart of the team's

---
 rtl/serial_add_pkg.sv | 5 +
 rtl/full_add_cell.sv | 11 +
 rtl/serial_adder.sv | 119 +++++++++++
 tb/tb_serial_adder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM encoding and default width for the bit-serial adder.
package serial_add_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int W_DEF = 8;
endpackage

// File: rtl/full_add_cell.sv
// full_add_cell: single-bit combinational full adder used as the serial slice.
module full_add_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder built from one full-adder cell and a carry flop.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_adder
    import serial_add_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int CW = $clog2(W);

    state_t         state_q, state_d;
    logic [W-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d, sum_q, sum_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           carry_q, carry_d, cout_q, cout_d;
    logic           s, c;
`ifdef SERIAL_ADD_OVF_EN
    logic           ovf_q, ovf_d;
`endif

    full_add_cell u_fa (
        .x (a_sh_q[0]),
        .y (b_sh_q[0]),
        .ci(carry_q),
        .s (s),
        .co(c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                a_sh_d  = a;
                b_sh_d  = b;
                carry_d = cin;
                cnt_d   = '0;
                sum_d   = '0;
                cout_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                ovf_d   = 1'b0;
`endif
                state_d = SHIFT;
            end
            SHIFT: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                sum_d   = {s, sum_q[W-1:1]};
                carry_d = c;
                cnt_d   = cnt_q + CW'(1);
                // carry_q here is the carry into the MSB on the last slice
                if (cnt_q == CW'(W - 1)) begin
                    cout_d  = c;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = carry_q ^ c;
`endif
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random and directed stimulus against an arithmetic model of the serial adder.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    // model: cycles remaining in the current add, its full result and overflow flag
    int       rem = 0;
    logic [W:0] res = '0;
    logic     m_ovf = 1'b0;

    serial_adder #(.W(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem   <= 0;
            res   <= '0;
            m_ovf <= 1'b0;
        end else if (rem > 0) begin
            rem <= rem - 1;
        end else if (start) begin
            rem   <= W + 1;
            res   <= {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            m_ovf <= (a[W-1] == b[W-1]) && (((a + b + W'(cin)) >> (W - 1)) != W'(a[W-1]));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            int j;
            logic [W-1:0] es;
            j  = (rem == 0) ? W : W + 1 - rem;
            es = W'(((2*W)'(res[W-1:0]) << W) >> j);
            chk("busy", 32'(busy), 32'(rem != 0));
            chk("done", 32'(done), 32'(rem == 1));
            chk("sum", 32'(sum), 32'(es));
            chk("cout", 32'(cout), 32'(rem <= 1 ? res[W] : 1'b0));
`ifdef SERIAL_ADD_OVF_EN
            chk("ovf", 32'(ovf), 32'(rem <= 1 ? m_ovf : 1'b0));
`endif
            if (done) done_cnt++;
        end
    end

    // Called just after a rising edge with the DUT idle; returns just after the edge leaving DONE.
    task automatic run_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, output int lat);
        logic got = 1'b0;
        a = x; b = y; cin = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = 0;
        for (int i = 0; i < 3 * W && !got; i++) begin
            @(negedge clk);
            lat++;
            got = done;
        end
        if (!got) chk("done_timeout", 32'(got), 32'(1));
        @(posedge clk); #1;
    endtask

    task automatic expect_res(input string nm, input logic [W-1:0] s, input logic co, input logic ov);
        chk({nm, "_sum"}, 32'(sum), 32'(s));
        chk({nm, "_cout"}, 32'(cout), 32'(co));
`ifdef SERIAL_ADD_OVF_EN
        chk({nm, "_ovf"}, 32'(ovf), 32'(ov));
`else
        if (ov) checks += 0;
`endif
    endtask

    initial begin
        int lat, d0;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf", 32'(ovf), 0);
`endif
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        run_add(8'h0F, 8'h01, 1'b0, lat);
        chk("t1_latency", 32'(lat), 32'(W + 1));
        expect_res("t1", 8'h10, 1'b0, 1'b0);
        run_add(8'hFF, 8'h01, 1'b0, lat);
        expect_res("t2", 8'h00, 1'b1, 1'b0);
        run_add(8'h7F, 8'h01, 1'b0, lat);
        expect_res("t3a", 8'h80, 1'b0, 1'b1);
        run_add(8'h80, 8'h80, 1'b0, lat);
        expect_res("t3b", 8'h00, 1'b1, 1'b1);

        d0 = done_cnt;
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 8'hAA; b = 8'hAA;
        repeat (W + 1) @(posedge clk);
        #1 start = 1'b0;
        chk("t4_done_pulses", 32'(done_cnt - d0), 1);
        expect_res("t4", 8'h02, 1'b0, 1'b0);

        d0 = done_cnt;
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_sum", 32'(sum), 0);
        chk("t5_cout", 32'(cout), 0);
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (W + 4) @(posedge clk);
        #1 chk("t5_no_done", 32'(done_cnt - d0), 0);
        run_add(8'h05, 8'h03, 1'b1, lat);
        expect_res("t5", 8'h09, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            logic [W-1:0] x, y;
            logic ci;
            logic [W:0] r;
            x = W'($urandom); y = W'($urandom); ci = (i % 3 == 0) ? 1'b1 : 1'($urandom);
            r = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
            run_add(x, y, ci, lat);
            chk("t6_sum", 32'(sum), 32'(r[W-1:0]));
            chk("t6_cout", 32'(cout), 32'(r[W]));
        end

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 run_add(W'($urandom), W'($urandom), 1'($urandom), lat);
            chk("t7_latency", 32'(lat), 32'(W + 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
